ifq_buffer: RTL and testbench



---
 rtl/ifq_buffer.sv | 107 ++++++++++
 tb/tb_ifq_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ifq_buffer.sv
// ifq_buffer: instruction fetch queue between the IFU and decode.
// Holds up to DEPTH {pc, inst, misalign} entries and releases them in order
// to decode over a valid/ready handshake. A flush discards every entry.
// Optional feature macro: IFQ_BYPASS_EN. It adds a zero-latency path from
// in_* to out_* while the queue is empty.
module ifq_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_misalign,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Storage is never read before it is written, so it has no reset.
  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_inst [DEPTH];
  logic          r_mis  [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_head_vld, w_byp, w_push, w_pop, w_in_mis;

  assign w_head_vld = (r_count != '0);
  assign w_in_mis   = (in_pc[1:0] != 2'b00);

`ifdef IFQ_BYPASS_EN
  // Empty queue: the incoming pair is offered to decode in the same cycle.
  assign w_byp = !w_head_vld && in_valid && !flush;
`else
  assign w_byp = 1'b0;
`endif

  // A full queue refuses pushes even when a pop happens in the same cycle,
  // so in_ready has no path from out_ready.
  assign in_ready  = (r_count != FULL) && !flush;
  assign out_valid = (w_head_vld || w_byp) && !flush;

  // A bypassed pair that decode takes right away is never written.
  assign w_push = in_valid && in_ready && !(w_byp && out_ready);
  assign w_pop  = out_valid && out_ready && w_head_vld;

  // Head entry (or the bypassed pair) to decode; empty values otherwise.
  always_comb begin
    out_pc       = RESET_PC;
    out_inst     = 32'h0;
    out_misalign = 1'b0;
    if (out_valid) begin
      if (w_byp) begin
        out_pc       = in_pc;
        out_inst     = in_inst;
        out_misalign = w_in_mis;
      end else begin
        out_pc       = r_pc[r_rd_ptr];
        out_inst     = r_inst[r_rd_ptr];
        out_misalign = r_mis[r_rd_ptr];
      end
    end
  end

  // Entry write at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]   <= in_pc;
      r_inst[r_wr_ptr] <= in_inst;
      r_mis[r_wr_ptr]  <= w_in_mis;
    end
  end

  // Pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_ifq_buffer.sv
// tb_ifq_buffer: scoreboard bench for ifq_buffer. Accepted pairs go into a
// queue; every cycle the head of that queue (or the empty values) is compared
// against out_*. The model follows IFQ_BYPASS_EN when it is defined.
module tb_ifq_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic                   clk = 1'b0;
  logic                   reset, flush, in_valid, out_ready;
  logic [31:0]            in_pc, in_inst;
  logic                   in_ready, out_valid, out_misalign;
  logic [31:0]            out_pc, out_inst;
  logic [$clog2(DEPTH):0] count;

  ifq_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_misalign(out_misalign), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] sb_pc   [$];
  logic [31:0] sb_inst [$];

  // One comparison: count it and report a mismatch.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle at the negedge, check outputs, then advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rdy, input logic fl);
    logic        e_ov, e_ir, byp, push, pop;
    logic [31:0] e_pc, e_inst;
    logic        e_mis;
    int          sz;
    in_valid = v; in_pc = pc; in_inst = inst; out_ready = rdy; flush = fl;
    #1;
    sz  = sb_pc.size();
`ifdef IFQ_BYPASS_EN
    byp = (sz == 0) && v && !fl;
`else
    byp = 1'b0;
`endif
    e_ir = (sz < DEPTH) && !fl;
    e_ov = ((sz != 0) || byp) && !fl;
    e_pc = RESET_PC; e_inst = 32'h0; e_mis = 1'b0;
    if (e_ov) begin
      e_pc   = byp ? pc   : sb_pc[0];
      e_inst = byp ? inst : sb_inst[0];
      e_mis  = (e_pc[1:0] != 2'b00);
    end
    chk("in_ready",     {31'b0, in_ready},     {31'b0, e_ir});
    chk("out_valid",    {31'b0, out_valid},    {31'b0, e_ov});
    chk("count",        32'(count),            32'(sz));
    chk("out_pc",       out_pc,                e_pc);
    chk("out_inst",     out_inst,              e_inst);
    chk("out_misalign", {31'b0, out_misalign}, {31'b0, e_mis});
    push = v && e_ir && !(byp && rdy);
    pop  = e_ov && rdy && (sz != 0);
    if (fl) begin
      sb_pc.delete(); sb_inst.delete();
    end else begin
      if (pop)  begin void'(sb_pc.pop_front()); void'(sb_inst.pop_front()); end
      if (push) begin sb_pc.push_back(pc); sb_inst.push_back(inst); end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'h2000_0000 ^ (pc << 4) ^ 32'h1;
  endfunction

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    // Reset values appear without any clock edge.
    #5;
    chk("rst_count",     32'(count),          32'd0);
    chk("rst_out_valid", {31'b0, out_valid},  32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},   32'd1);
    chk("rst_out_pc",    out_pc,              32'h3000);
    chk("rst_out_inst",  out_inst,            32'h0);
    chk("rst_misalign",  {31'b0, out_misalign}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two pushes held back, then drained in order.
    step(1, 32'h3000, 32'h2008_0001, 0, 0);
    step(1, 32'h3004, 32'h2009_0002, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Fill to full; 0x3010 is refused until a slot frees.
    for (int i = 0; i < 5; i++) step(1, 32'h3000 + 32'(4*i), ins(32'h3000 + 32'(4*i)), 0, 0);
    step(1, 32'h3010, ins(32'h3010), 1, 0);
    step(1, 32'h3010, ins(32'h3010), 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);

    // Simultaneous push and pop at count 2.
    step(1, 32'h3000, ins(32'h3000), 0, 0);
    step(1, 32'h3004, ins(32'h3004), 0, 0);
    step(1, 32'h3008, ins(32'h3008), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

    // Flush with in_valid and out_ready asserted.
    for (int i = 0; i < 3; i++) step(1, 32'h3100 + 32'(4*i), ins(32'h3100 + 32'(4*i)), 0, 0);
    step(1, 32'h3200, ins(32'h3200), 1, 1);
    step(0, 0, 0, 1, 0);

    // Misaligned PC, then empty queue push with out_ready high.
    step(1, 32'h3002, ins(32'h3002), 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h3000, 32'h2008_0001, 1, 0);
    step(0, 0, 0, 1, 0);

    // Asynchronous reset mid-stream, away from any clock edge.
    step(1, 32'h3300, ins(32'h3300), 0, 0);
    step(1, 32'h3304, ins(32'h3304), 0, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_count",     32'(count),         32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_out_pc",    out_pc,             32'h3000);
    sb_pc.delete(); sb_inst.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Random traffic with occasional flushes and misaligned PCs.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pc;
      pc = 32'h3000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 7) == 0 ? 2 : 0);
      step(1'($urandom_range(0, 1)), pc, $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
